// File: rtl/cmem_ctrl.sv
// cmem_ctrl: write/read sequencer for the 8-read-port coefficient memory.
// Each coefficient write goes to all 8 banks at the same address. Each start
// runs ceil(n/8) read passes of 8 taps for the MAC array. cmem registers A/D
// internally but samples WEN/CEN directly, so WEN/CEN are issued one cycle
// after the address/data they belong to.
module cmem_ctrl #(
  parameter int DW    = 16,
  parameter int AW    = 6,
  parameter int LANES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AW:0]           cfg_ntaps,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DW-1:0]         wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [LANES*AW-1:0]   cm_addr,
  output logic [DW-1:0]         cm_d,
  output logic                  cm_wen,
  output logic                  cm_cen,
  output logic                  tap_valid,
  output logic [LANES-1:0]      tap_en,
  output logic [2:0]            tap_pass,
  output logic                  tap_first,
  output logic                  tap_last
);

  localparam int NCOEF = 1 << AW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef logic [AW:0] cnt_t;

  state_t           state_q, state_d;
  cnt_t             n_q;        // latched tap count, 0..64
  cnt_t             n_clamp;
  logic [2:0]       pass_q;     // pass whose addresses are on cm_addr
  logic [2:0]       last_q;     // index of the final pass
  logic [2:0]       last_d;
  logic             wr_pend_q;  // cm_addr/cm_d currently carry a write
  logic             start_acc;
  logic             wr_acc;
  logic             in_run;
  logic             final_pass;
  logic [LANES-1:0] en_mask;

  // Lane i of pass p reads coefficient 8p+i; unused lanes still get 8p+i.
  function automatic logic [LANES*AW-1:0] lane_addrs(input logic [2:0] pass);
    logic [LANES*AW-1:0] a;
    a = '0;
    for (int i = 0; i < LANES; i++) begin
      a[i*AW +: AW] = {pass, 3'(i)};
    end
    return a;
  endfunction

  // start wins over a simultaneous write; nothing is accepted outside IDLE.
  assign wr_ready = (state_q == IDLE) && !start && !rst;
  assign busy     = (state_q != IDLE);

  // Next-state logic, handshake decode and per-pass lane mask.
  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    state_d    = state_q;
    n_clamp    = (int'(cfg_ntaps) > NCOEF) ? cnt_t'(NCOEF) : cfg_ntaps;
    last_d     = 3'((int'(n_clamp) - 1) >> 3);
    start_acc  = (state_q == IDLE) && start;
    wr_acc     = wr_valid && wr_ready;
    in_run     = (state_q == RUN);
    final_pass = in_run && (pass_q == last_q);
    en_mask    = '0;
    for (int i = 0; i < LANES; i++) begin
      en_mask[i] = ({1'b0, pass_q, 3'(i)} < n_q);
    end
    case (state_q)
      IDLE:    if (start_acc && (n_clamp != '0)) state_d = RUN;
      RUN:     if (final_pass) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Address/data path, pass counter and the one-cycle-late WEN/CEN/tap pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q       <= '0;
      pass_q    <= '0;
      last_q    <= '0;
      wr_pend_q <= 1'b0;
      cm_addr   <= '0;
      cm_d      <= '0;
      cm_wen    <= 1'b1;
      cm_cen    <= 1'b1;
      tap_valid <= 1'b0;
      tap_en    <= '0;
      tap_pass  <= '0;
      tap_first <= 1'b0;
      tap_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      // Second stage: strobes for whatever cm_addr/cm_d held this cycle.
      wr_pend_q <= wr_acc;
      cm_wen    <= !wr_pend_q;
      cm_cen    <= !(wr_pend_q || in_run);
      tap_valid <= in_run;
      tap_en    <= in_run ? en_mask : '0;
      tap_pass  <= in_run ? pass_q : 3'd0;
      tap_first <= in_run && (pass_q == 3'd0);
      tap_last  <= final_pass;
      done      <= final_pass || (start_acc && (n_clamp == '0));

      // First stage: present the next address (and data for writes).
      if (start_acc) begin
        n_q    <= n_clamp;
        last_q <= last_d;
        pass_q <= '0;
        if (n_clamp != '0) cm_addr <= lane_addrs(3'd0);
      end else if (wr_acc) begin
        cm_addr <= {LANES{wr_addr}};
        cm_d    <= wr_data;
      end else if (in_run && !final_pass) begin
        pass_q  <= pass_q + 3'd1;
        cm_addr <= lane_addrs(pass_q + 3'd1);
      end
    end
  end

endmodule

// File: tb/tb_cmem_ctrl.sv
// Testbench for cmem_ctrl: a behavioural cmem, a cycle-schedule reference
// model checked every cycle, a table of read-sequence vectors, hand-written
// corner sequences and a randomized phase.
module tb_cmem_ctrl;

  localparam int MAXC = 8192;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  cfg_ntaps;
  logic        wr_valid;
  logic        wr_ready;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic        busy;
  logic        done;
  logic [47:0] cm_addr;
  logic [15:0] cm_d;
  logic        cm_wen;
  logic        cm_cen;
  logic        tap_valid;
  logic [7:0]  tap_en;
  logic [2:0]  tap_pass;
  logic        tap_first;
  logic        tap_last;

  cmem_ctrl dut (
    .clk(clk), .rst(rst), .cfg_ntaps(cfg_ntaps),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done),
    .cm_addr(cm_addr), .cm_d(cm_d), .cm_wen(cm_wen), .cm_cen(cm_cen),
    .tap_valid(tap_valid), .tap_en(tap_en), .tap_pass(tap_pass),
    .tap_first(tap_first), .tap_last(tap_last)
  );

  initial forever #5 clk = ~clk;

  // Behavioural cmem: A/D registered on the rising edge, CEN/WEN acted on at the falling edge.
  logic [5:0]  a_reg [8];
  logic [15:0] d_reg;
  logic [15:0] mem [8][64];
  logic [15:0] q [8];

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) a_reg[i] <= cm_addr[i*6 +: 6];
    d_reg <= cm_d;
  end

  always @(negedge clk) begin
    if (cm_cen === 1'b0) begin
      if (cm_wen === 1'b0) for (int i = 0; i < 8; i++) mem[i][a_reg[i]] <= d_reg;
      else                 for (int i = 0; i < 8; i++) q[i] <= mem[i][a_reg[i]];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, got, exp);
  endtask

  // Reference model: accepted requests are expanded into a per-cycle schedule of expected outputs.
  bit          wen_low [MAXC];
  bit          cen_low [MAXC];
  bit          tv_a    [MAXC];
  bit          done_a  [MAXC];
  bit          busy_a  [MAXC];
  bit          first_a [MAXC];
  bit          last_a  [MAXC];
  bit [7:0]    en_a    [MAXC];
  bit [2:0]    pass_a  [MAXC];
  bit          addr_set[MAXC];
  bit [47:0]   addr_v  [MAXC];
  bit          d_set   [MAXC];
  bit [15:0]   d_v     [MAXC];
  bit          commit_set [MAXC];
  bit [5:0]    commit_addr[MAXC];
  bit [15:0]   commit_data[MAXC];

  int          seq_end = -1;     // last cycle of the current read sequence
  logic [47:0] exp_addr = '0;
  logic [15:0] exp_d = '0;
  logic [15:0] coef_ref [64];
  bit          written [64];
  bit          idle;
  bit          exp_ready;
  int          wen_run = 0;
  int          max_wen_run = 0;
  int          wen_lo_seen = 0;
  int          tv_seen = 0;
  int          done_seen = 0;
  logic [15:0] last_q [8];

  function automatic void clear_after(input int c);
    for (int k = c + 1; k <= c + 12 && k < MAXC; k++) begin
      wen_low[k] = 0; cen_low[k] = 0; tv_a[k] = 0; done_a[k] = 0; busy_a[k] = 0;
      first_a[k] = 0; last_a[k] = 0; en_a[k] = '0; pass_a[k] = '0;
      addr_set[k] = 0; d_set[k] = 0; commit_set[k] = 0;
    end
  endfunction

  function automatic void schedule_read(input int t, input int ntaps);
    int n, np;
    n = (ntaps > 64) ? 64 : ntaps;
    if (n == 0) begin
      done_a[t+1] = 1;
      return;
    end
    np = (n + 7) / 8;
    for (int p = 0; p < np; p++) begin
      addr_set[t+1+p] = 1;
      for (int i = 0; i < 8; i++) begin
        addr_v[t+1+p][i*6 +: 6] = 6'(8*p + i);
        en_a[t+2+p][i] = (8*p + i < n);
      end
      cen_low[t+2+p] = 1;
      tv_a[t+2+p]    = 1;
      pass_a[t+2+p]  = 3'(p);
      first_a[t+2+p] = (p == 0);
      last_a[t+2+p]  = (p == np - 1);
    end
    done_a[t+1+np] = 1;
    for (int k = t + 1; k <= t + 1 + np; k++) busy_a[k] = 1;
    seq_end = t + 1 + np;
  endfunction

  // Per-cycle monitor: compare every output with the schedule, then schedule this cycle's requests.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (commit_set[cyc]) begin
        coef_ref[commit_addr[cyc]] = commit_data[cyc];
        written[commit_addr[cyc]]  = 1;
      end
      if (addr_set[cyc]) exp_addr = addr_v[cyc];
      if (d_set[cyc])    exp_d    = d_v[cyc];
      idle      = (cyc > seq_end);
      exp_ready = idle && !start && !rst;
      if (cyc >= 1) begin
        check("cm_addr",   64'(cm_addr),   64'(exp_addr));
        check("cm_d",      64'(cm_d),      64'(exp_d));
        check("cm_wen",    64'(cm_wen),    64'(!wen_low[cyc]));
        check("cm_cen",    64'(cm_cen),    64'(!cen_low[cyc]));
        check("tap_valid", 64'(tap_valid), 64'(tv_a[cyc]));
        check("tap_en",    64'(tap_en),    64'(en_a[cyc]));
        check("tap_pass",  64'(tap_pass),  64'(pass_a[cyc]));
        check("tap_first", 64'(tap_first), 64'(first_a[cyc]));
        check("tap_last",  64'(tap_last),  64'(last_a[cyc]));
        check("busy",      64'(busy),      64'(busy_a[cyc]));
        check("done",      64'(done),      64'(done_a[cyc]));
        check("wr_ready",  64'(wr_ready),  64'(exp_ready));
      end
      if (tv_a[cyc]) begin
        for (int i = 0; i < 8; i++) begin
          int idx;
          idx = 8 * int'(pass_a[cyc]) + i;
          if (en_a[cyc][i] && written[idx]) check("tap_q", 64'(q[i]), 64'(coef_ref[idx]));
          last_q[i] = q[i];
        end
      end
      if (cm_wen === 1'b0) begin
        wen_run++;
        wen_lo_seen++;
        if (wen_run > max_wen_run) max_wen_run = wen_run;
      end else begin
        wen_run = 0;
      end
      if (tap_valid === 1'b1) tv_seen++;
      if (done === 1'b1)      done_seen++;

      if (rst) begin
        clear_after(cyc);
        addr_set[cyc+1] = 1; addr_v[cyc+1] = '0;
        d_set[cyc+1]    = 1; d_v[cyc+1]    = '0;
        seq_end = cyc;
      end else if (idle && start) begin
        schedule_read(cyc, int'(cfg_ntaps));
      end else if (exp_ready && wr_valid) begin
        addr_set[cyc+1]    = 1; addr_v[cyc+1] = {8{wr_addr}};
        d_set[cyc+1]       = 1; d_v[cyc+1]    = wr_data;
        wen_low[cyc+2]     = 1;
        cen_low[cyc+2]     = 1;
        commit_set[cyc+2]  = 1;
        commit_addr[cyc+2] = wr_addr;
        commit_data[cyc+2] = wr_data;
      end
      cyc++;
    end
  end

  // Inputs change just after the rising edge; direct samples are taken after the falling edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #3;
  endtask

  task automatic wait_done(input int max_cycles, output int lat);
    bit seen;
    seen = 0;
    lat  = -1;
    for (int k = 1; k <= max_cycles && !seen; k++) begin
      sample();
      if (done === 1'b1) begin
        lat  = k;
        seen = 1;
      end else begin
        step();
      end
    end
  endtask

  typedef struct {
    int         ntaps;
    int         passes;
    logic [7:0] last_en;
    int         lat;
  } vec_t;

  vec_t       vecs [8];
  int         lat;
  int         npass;
  logic [7:0] last_en;

  initial begin
    vecs[0] = '{64,  8, 8'hFF, 9};
    vecs[1] = '{13,  2, 8'h1F, 3};
    vecs[2] = '{0,   0, 8'h00, 1};
    vecs[3] = '{100, 8, 8'hFF, 9};
    vecs[4] = '{1,   1, 8'h01, 2};
    vecs[5] = '{8,   1, 8'hFF, 2};
    vecs[6] = '{9,   2, 8'h01, 3};
    vecs[7] = '{63,  8, 8'h7F, 9};

    rst = 1'b1; start = 1'b0; wr_valid = 1'b0;
    wr_addr = '0; wr_data = '0; cfg_ntaps = '0;
    repeat (3) step();
    rst = 1'b0;
    sample();
    check("rst_wen",   64'(cm_wen),    64'(1));
    check("rst_cen",   64'(cm_cen),    64'(1));
    check("rst_ready", 64'(wr_ready),  64'(1));
    check("rst_busy",  64'(busy),      64'(0));
    check("rst_tv",    64'(tap_valid), 64'(0));

    // Single write of 0xA5A5 to address 5, then read it back on lane 5.
    step();
    wr_valid = 1'b1; wr_addr = 6'd5; wr_data = 16'hA5A5;
    step();
    wr_valid = 1'b0;
    sample();
    check("t2_addr", 64'(cm_addr), 64'({8{6'd5}}));
    check("t2_d",    64'(cm_d),    64'(16'hA5A5));
    check("t2_wen1", 64'(cm_wen),  64'(1));
    step(); sample();
    check("t2_wen2", 64'(cm_wen),  64'(0));
    check("t2_cen2", 64'(cm_cen),  64'(0));
    step(); sample();
    check("t2_wen3", 64'(cm_wen),  64'(1));
    check("t2_cen3", 64'(cm_cen),  64'(1));
    step();
    cfg_ntaps = 7'd6; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(20, lat);
    check("t2_lat", 64'(lat),       64'(2));
    check("t2_q5",  64'(last_q[5]), 64'(16'hA5A5));
    step();

    // Stream all 64 coefficients back to back.
    max_wen_run = 0;
    for (int a = 0; a < 64; a++) begin
      wr_valid = 1'b1; wr_addr = 6'(a); wr_data = 16'(32'h100 + a);
      step();
    end
    wr_valid = 1'b0;
    repeat (4) step();
    check("t3_wen_run", 64'(max_wen_run), 64'(64));

    // Read-sequence vectors.
    for (int v = 0; v < 8; v++) begin
      cfg_ntaps = 7'(vecs[v].ntaps); start = 1'b1;
      step();
      start = 1'b0;
      npass = 0; last_en = '0; lat = -1;
      for (int k = 1; k <= 20 && lat < 0; k++) begin
        sample();
        if (tap_valid === 1'b1) begin
          npass++;
          last_en = tap_en;
        end
        if (done === 1'b1) lat = k;
        else step();
      end
      check("vec_passes",  64'(npass),   64'(vecs[v].passes));
      check("vec_last_en", 64'(last_en), 64'(vecs[v].last_en));
      check("vec_lat",     64'(lat),     64'(vecs[v].lat));
      step(); sample();
      check("vec_busy_after", 64'(busy), 64'(0));
      if (v == 0) check("t3_q_p7l3", 64'(last_q[3]), 64'(16'h013B));
      step();
    end

    // start and write together: start wins, write dropped.
    cfg_ntaps = 7'd0; start = 1'b1;
    wr_valid = 1'b1; wr_addr = 6'd7; wr_data = 16'hDEAD;
    sample();
    check("t5_ready", 64'(wr_ready), 64'(0));
    step();
    start = 1'b0; wr_valid = 1'b0;
    sample();
    check("t5_done",   64'(done), 64'(1));
    check("t5_busy",   64'(busy), 64'(0));
    check("t5_d_held", 64'(cm_d), 64'(16'h013F));
    step(); sample();
    check("t5_wen", 64'(cm_wen), 64'(1));
    step();
    cfg_ntaps = 7'd13; start = 1'b1;
    wr_valid = 1'b1; wr_addr = 6'd7; wr_data = 16'hBEEF;
    step();
    start = 1'b0; wr_valid = 1'b0;
    wait_done(20, lat);
    check("t5_run_lat", 64'(lat),  64'(3));
    check("t5_d_kept",  64'(cm_d), 64'(16'h013F));
    step();

    // Reset during pass 3 of a 64-tap run.
    cfg_ntaps = 7'd64; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    sample();
    check("t6_tv",    64'(tap_valid), 64'(1));
    check("t6_pass3", 64'(tap_pass),  64'(3));
    step();
    rst = 1'b0; tv_seen = 0; done_seen = 0;
    sample();
    check("t6_rst_tv",   64'(tap_valid), 64'(0));
    check("t6_rst_busy", 64'(busy),      64'(0));
    check("t6_rst_done", 64'(done),      64'(0));
    check("t6_rst_cen",  64'(cm_cen),    64'(1));
    check("t6_rst_addr", 64'(cm_addr),   64'(0));
    repeat (12) step();
    check("t6_no_tv",   64'(tv_seen),   64'(0));
    check("t6_no_done", 64'(done_seen), 64'(0));

    // Write accepted one cycle before reset never reaches WEN.
    wr_valid = 1'b1; wr_addr = 6'd9; wr_data = 16'h5555; wen_lo_seen = 0;
    step();
    wr_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (6) step();
    check("t6_wen_never", 64'(wen_lo_seen), 64'(0));

    // Randomized traffic against the reference model.
    for (int k = 0; k < 2500; k++) begin
      rst      = ($urandom_range(0, 199) == 0);
      start    = ($urandom_range(0, 11) == 0);
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_addr  = 6'($urandom_range(0, 63));
      wr_data  = 16'($urandom);
      cfg_ntaps = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                              : 7'($urandom_range(1, 64));
      step();
    end
    rst = 1'b0; start = 1'b0; wr_valid = 1'b0;
    repeat (20) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cmem_ctrl.md
Name: cmem_ctrl

Overview:
- Sequencer for the 8-read-port coefficient memory (cmem) in the FIR core.
- Loads coefficients through a valid/ready write port. Each write is replicated into all 8 banks at the same address.
- On each sample start, issues ceil(ntaps/8) read passes, 8 taps per pass, to feed the MAC array.
- Compensates for the cmem internal input register: cmem registers A/D, but WEN/CEN are unregistered and sampled on the falling clock.

Parameters:
- DW, 16, coefficient width (matches cmem D/Q).
- AW, 6, per-lane address width (64 coefficients).
- LANES, 8, read lanes. Fixed at 8 to match cmem; other values are not supported.

Ports:
- clk  in  1  system clock; cmem shares it.
- rst  in  1  synchronous, active-high reset.
- cfg_ntaps  in  7  filter length; sampled on accepted start.
- wr_valid  in  1  coefficient write request.
- wr_ready  out  1  write accept.
- wr_addr  in  6  coefficient index.
- wr_data  in  16  coefficient value.
- start  in  1  begin one coefficient read sequence (one output sample).
- busy  out  1  read sequence in progress.
- done  out  1  one-cycle pulse, sequence complete.
- cm_addr  out  48  cmem A7..A0 packed; lane i at [6i+5:6i].
- cm_d  out  16  cmem D.
- cm_wen  out  1  cmem WEN, active low.
- cm_cen  out  1  cmem CEN, active low.
- tap_valid  out  1  cmem Q0..Q7 are valid at the rising edge that ends this cycle.
- tap_en  out  8  per-lane valid mask for the current pass.
- tap_pass  out  3  pass index of the data currently valid.
- tap_first  out  1  first pass of the sequence (MAC clears accumulator).
- tap_last  out  1  final pass of the sequence.

Behaviour:
- Reset values (outputs reach them at the first rising edge with rst=1):
  - cm_wen=1, cm_cen=1 (OFF).
  - cm_addr=0, cm_d=0.
  - tap_valid, tap_en, tap_pass, tap_first, tap_last, busy, done all 0.
  - State returns to IDLE.
- Reset mid-operation:
  - Any in-flight write whose address was issued but whose WEN was not yet asserted is discarded.
  - No further tap_valid or done is produced.
- States: IDLE, RUN, DRAIN.
- wr_ready = (state==IDLE) && !start && !rst. It is combinational. start has priority over a simultaneous write.
- Write timing:
  - Handshake accepted in cycle t.
  - Cycle t+1: cm_addr = wr_addr replicated to all 8 lanes; cm_d = wr_data.
  - Cycle t+2: cm_wen=0 and cm_cen=0 (delayed one cycle to match cmem's A/D register).
  - Back-to-back writes are allowed, one per cycle; the WEN/CEN pipeline remains continuously low.
- Start in IDLE (cycle t):
  - Latch n = min(cfg_ntaps, 64).
  - Pass count P = ceil(n/8).
  - busy=1 from t+1.
- Passes with n=0: no reads and no tap_valid. done=1 in t+1, busy=0, return to IDLE.
- RUN timing:
  - Pass p (0..P-1) presents cm_addr lane i = 8p+i in cycle t+1+p.
  - cm_cen=0 and cm_wen=1 in cycle t+2+p.
  - tap_valid=1 in cycle t+2+p, with tap_pass=p and tap_en[i] = (8p+i < n).
  - tap_first = (p==0); tap_last = (p==P-1).
  - After the last address, go to DRAIN. In DRAIN, cm_cen stays low for the final pass, then returns to 1.
- Completion: done pulses in the same cycle as tap_last. busy drops in the following cycle, and the controller then returns to IDLE.
- While busy:
  - start is ignored.
  - wr_ready=0.
  - cfg_ntaps changes have no effect.
- Between operations: cm_addr holds its last value, and cm_d holds its last value.
- Addresses never exceed 63; unused lanes in the last pass are still driven to 8p+i.

Test Plan:
1. Reset hold, then release -> cm_wen=cm_cen=1, wr_ready=1, busy=0, tap_valid=0.
2. Write addr 5, data 0xA5A5 -> cycle t+1: all 8 lanes of cm_addr = 5 and cm_d = 0xA5A5; cycle t+2: cm_wen=cm_cen=0 for exactly one cycle. A subsequent read of tap 5 on lane 5 returns 0xA5A5.
3. Stream 64 writes (data = 0x100+addr) on consecutive cycles -> WEN low for 64 contiguous cycles. Then start with ntaps=64 -> 8 tap_valid cycles, pass p lane i Q = 0x100+8p+i, tap_en=0xFF, tap_first on pass 0, tap_last/done on pass 7.
4. ntaps=13, start -> 2 passes: tap_en=0xFF then 0x1F; done with second tap_valid; busy low the next cycle.
5. start and wr_valid asserted together in IDLE -> wr_ready=0, write not accepted, run proceeds. With ntaps=0 -> done one cycle after start and no tap_valid. With ntaps=100 -> clamped to 8 passes.
6. rst asserted during pass 3 of a 64-tap run -> next edge: outputs at reset values, no done. A write issued one cycle before rst -> cm_wen never goes low.
